// File: rtl/clic_dispatch_if.sv
// Shared CLIC width constants and the dispatch-stage port bundle.
// master is the dispatcher; slave is the arbiter/core/pending-file side.
package common_pkg;
   localparam int NR_INDEX_BITS = 5;
   localparam int NR_PRIO_BITS = 3;
endpackage

interface clic_dispatch_if #(
   parameter int NR_INDEX_BITS = common_pkg::NR_INDEX_BITS,
   parameter int NR_PRIO_BITS = common_pkg::NR_PRIO_BITS,
   parameter int STACK_DEPTH = 4
);
   localparam int DEPTH_BITS = $clog2(STACK_DEPTH + 1);

   logic arb_is_interrupt;
   logic [NR_INDEX_BITS-1:0] arb_index;
   logic [NR_PRIO_BITS-1:0] arb_prio;
   logic irq_req;
   logic [NR_INDEX_BITS-1:0] irq_index;
   logic irq_ack;
   logic irq_ret;
   logic clr_pending;
   logic [NR_INDEX_BITS-1:0] clr_index;
   logic [NR_PRIO_BITS-1:0] threshold;
   logic [DEPTH_BITS-1:0] depth;
   logic err;

   modport master (
      input arb_is_interrupt, arb_index, arb_prio, irq_ack, irq_ret,
      output irq_req, irq_index, clr_pending, clr_index, threshold, depth, err
   );

   modport slave (
      output arb_is_interrupt, arb_index, arb_prio, irq_ack, irq_ret,
      input irq_req, irq_index, clr_pending, clr_index, threshold, depth, err
   );
endinterface

// File: rtl/clic_dispatch.sv
// CLIC core-side dispatch: threshold filtering, req/ack to the core,
// pending-clear pulse and a nesting stack of preempted thresholds.
module clic_dispatch #(
   parameter int NR_INDEX_BITS = common_pkg::NR_INDEX_BITS,
   parameter int NR_PRIO_BITS = common_pkg::NR_PRIO_BITS,
   parameter int STACK_DEPTH = 4
) (
   input logic clk,
   input logic reset,
   clic_dispatch_if.master bus
);
   localparam int DEPTH_BITS = $clog2(STACK_DEPTH + 1);
   localparam int PTR_BITS = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, REQ, CLEAR} state_t;

   state_t state, state_next;
   logic accept, push, pop;
   logic [DEPTH_BITS-1:0] depth_q, top_ptr;
   logic [NR_PRIO_BITS-1:0] threshold_q, lat_prio;
   logic err_q;
   logic [NR_PRIO_BITS-1:0] stack [STACK_DEPTH];

   assign top_ptr = depth_q - DEPTH_BITS'(1);
   assign bus.threshold = threshold_q;
   assign bus.depth = depth_q;
   assign bus.err = err_q;

   always_comb begin
      state_next = state;
      accept = 1'b0;
      push = 1'b0;
      pop = bus.irq_ret && (depth_q != '0);
      case (state)
         IDLE: begin
            // Compare uses the pre-pop threshold; a same-cycle return only lowers it next cycle.
            accept = bus.arb_is_interrupt && (bus.arb_prio > threshold_q)
                     && (depth_q < DEPTH_BITS'(STACK_DEPTH));
            if (accept) state_next = REQ;
         end
         REQ: begin
            if (bus.irq_ack) begin
               push = 1'b1;
               state_next = CLEAR;
            end
         end
         CLEAR: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.irq_req <= 1'b0;
         bus.irq_index <= '0;
         bus.clr_pending <= 1'b0;
         bus.clr_index <= '0;
         lat_prio <= '0;
         threshold_q <= '0;
         depth_q <= '0;
         err_q <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
      end else begin
         bus.irq_req <= (state_next == REQ);
         bus.clr_pending <= (state_next == CLEAR);
         if (accept) begin
            bus.irq_index <= bus.arb_index;
            lat_prio <= bus.arb_prio;
         end
         if (push) bus.clr_index <= bus.irq_index;
         if (bus.irq_ret && (depth_q == '0)) err_q <= 1'b1;
         // Pop-then-push leaves the stack as it was; only the running priority moves.
         if (push && pop) begin
            threshold_q <= lat_prio;
         end else if (push) begin
            stack[depth_q[PTR_BITS-1:0]] <= threshold_q;
            threshold_q <= lat_prio;
            depth_q <= depth_q + DEPTH_BITS'(1);
         end else if (pop) begin
            threshold_q <= stack[top_ptr[PTR_BITS-1:0]];
            depth_q <= top_ptr;
         end
      end
   end
endmodule
